// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S master.
// Slot geometry is fixed at 32 bit clocks per channel.
package i2s_pkg;

   localparam int SLOT_BITS  = 32;
   localparam int FRAME_BITS = 64;
   localparam int SAMPLE_W   = 16;

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } stereo_sample_t;

   // Slot positions 1..w carry sample bits; position 0 is the I2S delay bit.
   function automatic logic in_slot(input logic [4:0] p, input int w);
      return (p != 5'd0) && (int'(p) <= w);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// DEPTH is a power of two, at least 2.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/i2s_master.sv
// Philips-format I2S master: 64-SCLK frames, buffered playback,
// capture of the codec output into a stereo frame register.
module i2s_master
   import i2s_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int SCLK_DIV   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [2*DATA_W-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [2*DATA_W-1:0] rx_data,
   output logic                rx_valid,
   output logic                underrun,
   input  logic                underrun_clr,
   output logic                sclk,
   output logic                lrclk,
   output logic                sdout,
   input  logic                sdin
);

   localparam int DW = $clog2(SCLK_DIV);
   localparam int FW = 2 * DATA_W;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_RISE = DW'(SCLK_DIV / 2 - 1);
   localparam logic [5:0]    BIT_LAST = 6'(FRAME_BITS - 1);

   logic [DW-1:0]     div_cnt;
   logic [5:0]        bit_cnt;
   logic              first;
   logic [DATA_W-1:0] frm_l, frm_r;
   logic [DATA_W-1:0] left_sr, right_sr;
   logic [FW-1:0]     fifo_rdata;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              fall_tick, rise_tick, frame_start, pop;

   logic [5:0]        nb;
   logic [4:0]        np;
   logic [4:0]        sh;
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] shifted;
   logic              nxt_sd;

   assign fall_tick   = enable && (div_cnt == DIV_LAST);
   assign rise_tick   = enable && (div_cnt == DIV_RISE);
   assign frame_start = fall_tick && (bit_cnt == BIT_LAST);
   assign pop         = frame_start && !fifo_empty;
   assign tx_ready    = (fifo_count != CW'(FIFO_DEPTH));

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_valid && !fifo_full),
      .wdata   (tx_data),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Data bit for the position entered at the next fall tick.
   always_comb begin
      nb      = bit_cnt + 6'd1;
      np      = nb[4:0];
      word    = nb[5] ? frm_r : frm_l;
      sh      = 5'(DATA_W) - np;
      shifted = word >> sh;
      nxt_sd  = in_slot(np, DATA_W) && shifted[0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt  <= DIV_LAST;
         bit_cnt  <= BIT_LAST;
         first    <= 1'b1;
         frm_l    <= '0;
         frm_r    <= '0;
         left_sr  <= '0;
         right_sr <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         sclk     <= 1'b0;
         lrclk    <= 1'b0;
         sdout    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (!enable) begin
            div_cnt <= DIV_LAST;
            bit_cnt <= BIT_LAST;
            first   <= 1'b1;
            sclk    <= 1'b0;
            lrclk   <= 1'b0;
            sdout   <= 1'b0;
         end else begin
            div_cnt <= fall_tick ? '0 : div_cnt + DW'(1);
            if (fall_tick) begin
               sclk    <= 1'b0;
               bit_cnt <= nb;
               lrclk   <= nb[5];
               sdout   <= nxt_sd;
            end
            if (rise_tick) begin
               sclk <= 1'b1;
               if (in_slot(bit_cnt[4:0], DATA_W)) begin
                  if (bit_cnt[5]) right_sr <= {right_sr[DATA_W-2:0], sdin};
                  else            left_sr  <= {left_sr[DATA_W-2:0], sdin};
               end
            end
            // An empty FIFO plays a silent frame.
            if (frame_start) begin
               frm_l <= pop ? fifo_rdata[FW-1 -: DATA_W] : '0;
               frm_r <= pop ? fifo_rdata[DATA_W-1:0] : '0;
               first <= 1'b0;
               if (!first) begin
                  rx_data  <= {left_sr, right_sr};
                  rx_valid <= 1'b1;
               end
            end
         end
         if (frame_start && fifo_empty) underrun <= 1'b1;
         else if (underrun_clr)         underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_master.sv
// Scoreboard bench for i2s_master with sdout looped back to sdin.
// Frames, rx words, handshake and pin timing are checked against a model.
module tb_i2s_master;
   import i2s_pkg::*;

   localparam int DW  = 16;
   localparam int DIV = 16;
   localparam int DEP = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        tx_valid = 1'b0;
   logic        underrun_clr = 1'b0;
   logic [31:0] tx_data = '0;
   logic        tx_ready, rx_valid, underrun;
   logic        sclk, lrclk, sdout, sdin;
   logic [31:0] rx_data;

   assign sdin = sdout;

   i2s_master #(
      .DATA_W     (DW),
      .SCLK_DIV   (DIV),
      .FIFO_DEPTH (DEP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .sclk         (sclk),
      .lrclk        (lrclk),
      .sdout        (sdout),
      .sdin         (sdin)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] exp_frame(input logic [31:0] w);
      stereo_sample_t s;
      logic [63:0] f;
      s = w;
      f = '0;
      for (int p = 0; p < 64; p++) begin
         int q;
         logic [15:0] smp;
         q = p % 32;
         smp = (p < 32) ? s.left : s.right;
         if (q >= 1 && q <= 16) f[p] = smp[16-q];
      end
      return f;
   endfunction

   // Edge-time sampling of inputs as the DUT sees them.
   bit          en_e = 1'b0;
   bit          en_p = 1'b0;
   bit          push_now = 1'b0;
   logic [31:0] push_word = '0;

   always begin
      @(posedge clk);
      cyc++;
      en_p = en_e;
      en_e = reset_n && enable;
      push_now = reset_n && tx_valid && tx_ready;
      push_word = tx_data;
   end

   logic [31:0] mq[$];
   logic [31:0] rxq[$];
   logic [31:0] cur = '0;
   logic [63:0] got = '0;
   logic [5:0]  pos = '0;
   bit          in_frame = 1'b0;
   bit          rise_ok = 1'b0;
   bit          rx_ok = 1'b0;
   bit          fs;
   logic        sclk_p = 1'b0;
   int          last_rise = 0;
   int          last_rx = 0;
   int          lr_err = 0;
   int          rx_seen = 0;

   always begin
      @(negedge clk);
      if (!reset_n) begin
         mq.delete();
         rxq.delete();
         in_frame = 1'b0;
         rise_ok = 1'b0;
         rx_ok = 1'b0;
      end else begin
         if (!en_e) begin
            in_frame = 1'b0;
            rise_ok = 1'b0;
            rx_ok = 1'b0;
            rxq.delete();
            chk("idle_pins", {61'd0, sclk, lrclk, sdout}, 64'd0);
         end else begin
            fs = !en_p || (in_frame && pos == 6'd63 && sclk_p && !sclk);
            if (fs) begin
               if (mq.size() == 0) begin
                  cur = '0;
                  chk("underrun_set", underrun, 1);
               end else begin
                  cur = mq.pop_front();
               end
               pos = '0;
               in_frame = 1'b1;
               lr_err = 0;
               got = '0;
            end else if (in_frame && sclk_p && !sclk) begin
               pos++;
            end
            if (!sclk_p && sclk) begin
               if (rise_ok) chk("sclk_period", cyc - last_rise, DIV);
               last_rise = cyc;
               rise_ok = 1'b1;
               if (in_frame) begin
                  got[pos] = sdout;
                  if (lrclk !== pos[5]) lr_err++;
                  if (pos == 6'd63) begin
                     chk("frame_bits", got, exp_frame(cur));
                     chk("lrclk_slot", lr_err, 0);
                     rxq.push_back(cur);
                  end
               end
            end
            if (sclk_p && !sclk && rise_ok)
               chk("sclk_high", cyc - last_rise, DIV / 2);
         end
         if (push_now) mq.push_back(push_word);
         chk("tx_ready", tx_ready, mq.size() < DEP);
         if (rx_valid) begin
            rx_seen++;
            if (rxq.size() == 0) begin
               chk("rx_unexpected", rx_valid, 0);
            end else begin
               chk("rx_data", rx_data, rxq.pop_front());
               if (rx_ok) chk("rx_period", cyc - last_rx, 64 * DIV);
               last_rx = cyc;
               rx_ok = 1'b1;
            end
         end
      end
      sclk_p = sclk;
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Enable is low at edge e.
   task automatic stop_at(input int e);
      wait_cyc(e - 1);
      enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] w);
      int n;
      n = 0;
      tx_data = w;
      tx_valid = 1'b1;
      while (!tx_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) chk("push_timeout", tx_ready, 1);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   localparam logic [31:0] W1 = 32'h1234_8001;
   localparam logic [31:0] W2 = 32'hFFFF_0000;

   initial begin
      int e0, e1, acc, n, rx0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_pins", {61'd0, sclk, lrclk, sdout}, 64'd0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_tx_ready", tx_ready, 1);
      #2 reset_n = 1'b1;
      @(negedge clk);
      wait_cyc(cyc + 2000);

      push(32'hA5A5_0F0F);
      enable = 1'b1;
      e0 = cyc + 1;
      stop_at(e0 + 1024);
      chk("no_underrun_t2", underrun, 0);

      push(W1);
      push(W2);
      push(W1);
      push(W2);
      chk("full_after4", tx_ready, 0);
      tx_data = W1;
      tx_valid = 1'b1;
      repeat (100) @(negedge clk);
      chk("held_5th", tx_ready, 0);
      rx0 = rx_seen;
      enable = 1'b1;
      e0 = cyc + 1;
      n = 0;
      while (!tx_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      acc = cyc + 1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("accept_5th", acc, e0 + 1);
      push(W2);
      stop_at(e0 + 6 * 1024);
      chk("rx_count", rx_seen - rx0, 5);
      chk("no_underrun_t3", underrun, 0);

      enable = 1'b1;
      e0 = cyc + 1;
      wait_cyc(e0 + 99);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      chk("clr_alone", underrun, 0);
      wait_cyc(e0 + 1023);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      chk("clr_vs_set", underrun, 1);
      stop_at(e0 + 2040);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      chk("clr_final", underrun, 0);

      push(32'hC3C3_5A5A);
      push(32'h0001_8000);
      enable = 1'b1;
      e0 = cyc + 1;
      stop_at(e0 + 330);
      chk("drop_pins", {61'd0, sclk, lrclk, sdout}, 64'd0);
      push(32'h8000_0001);
      push(32'h3C3C_C3C3);
      push(32'hDEAD_BEEF);
      chk("full_t6", tx_ready, 0);
      enable = 1'b1;
      e1 = cyc + 1;
      stop_at(e1 + 4096);
      chk("no_underrun_t6", underrun, 0);

      push(32'h7E81_FFFF);
      push(32'h0F0F_A5A5);
      enable = 1'b1;
      e0 = cyc + 1;
      wait_cyc(e0 + 700);
      #3 reset_n = 1'b0;
      enable = 1'b0;
      #1;
      chk("arst_pins", {61'd0, sclk, lrclk, sdout}, 64'd0);
      chk("arst_rx_valid", rx_valid, 0);
      chk("arst_rx_data", rx_data, 0);
      chk("arst_tx_ready", tx_ready, 1);
      @(negedge clk);
      #3 reset_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      e1 = cyc + 1;
      stop_at(e1 + 1020);
      chk("underrun_after_rst", underrun, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
